// File: rtl/nes_pkg.sv
// Shared constants for the NES video/controller subsystem: timing geometry, pad bit
// positions, sprite placement helpers and the 2C02 NTSC palette.
package nes_pkg;

    localparam int DIV     = 4;
    localparam int H_TOTAL = 341;
    localparam int H_VIS   = 256;
    localparam int V_TOTAL = 262;
    localparam int V_VIS   = 240;
    localparam int CNT_W   = 9;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int         SPRITE_SIZE    = 8;
    localparam logic [5:0] SPRITE_PAL_IDX = 6'h30;

    // Sprite home is centred on screen: (124,116) for the full 256x240 raster.
    function automatic logic [CNT_W-1:0] sprite_home(input int vis);
        return CNT_W'(vis / 2 - SPRITE_SIZE / 2);
    endfunction

    // Largest top-left coordinate keeping the sprite on screen: 248 / 232 at full size.
    function automatic logic [CNT_W-1:0] sprite_max(input int vis);
        return CNT_W'(vis - SPRITE_SIZE);
    endfunction

    // One-pixel move toward dec/inc, cancelled when both are pressed, clamped to 0..max_pos.
    function automatic logic [CNT_W-1:0] step_clamp(input logic [CNT_W-1:0] pos,
                                                    input logic             dec,
                                                    input logic             inc,
                                                    input logic [CNT_W-1:0] max_pos);
        logic [CNT_W-1:0] res;
        res = pos;
        if (dec && !inc && (pos != 9'd0)) begin
            res = pos - 9'd1;
        end else if (inc && !dec && (pos < max_pos)) begin
            res = pos + 9'd1;
        end else begin
            res = pos;
        end
        return res;
    endfunction

    localparam logic [23:0] PALETTE [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4,
        24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08,
        24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE,
        24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32,
        24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF,
        24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082,
        24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF,
        24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC,
        24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/nes_video_timing.sv
// Dot-clock phase, dot and scanline counters. All status outputs describe the dot being
// entered on the next clk edge so the top can register its outputs on that same edge.
module nes_video_timing
    import nes_pkg::*;
#(
    parameter int H_VIS_P   = H_VIS,
    parameter int H_TOTAL_P = H_TOTAL,
    parameter int V_VIS_P   = V_VIS,
    parameter int V_TOTAL_P = V_TOTAL
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic [CNT_W-1:0] dot_o,
    output logic [CNT_W-1:0] line_o,
    output logic             dot_adv_o,
    output logic             visible_o,
    output logic             dot_zero_o,
    output logic             line_zero_o,
    output logic             frame_tick_o
);

    localparam logic [1:0]       PHASE_LAST = 2'(DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL_P - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL_P - 1);
    localparam logic [CNT_W-1:0] H_END      = CNT_W'(H_VIS_P);
    localparam logic [CNT_W-1:0] V_END      = CNT_W'(V_VIS_P);

    logic [1:0]       phase_q, phase_d;
    logic [CNT_W-1:0] dot_q, dot_d;
    logic [CNT_W-1:0] line_q, line_d;
    logic             adv_s;

    // Next phase/dot/line; the dot only moves on the last phase of the current one.
    always_comb begin
        adv_s   = (phase_q == PHASE_LAST);
        phase_d = phase_q + 2'd1;
        dot_d   = dot_q;
        line_d  = line_q;
        if (adv_s) begin
            phase_d = 2'd0;
            if (dot_q == H_LAST) begin
                dot_d = 9'd0;
                if (line_q == V_LAST) begin
                    line_d = 9'd0;
                end else begin
                    line_d = line_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end else begin
            phase_d = phase_q + 2'd1;
        end
    end

    // Reset parks the counters one clk before line 0 / dot 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= PHASE_LAST;
            dot_q   <= H_LAST;
            line_q  <= V_LAST;
        end else begin
            phase_q <= phase_d;
            dot_q   <= dot_d;
            line_q  <= line_d;
        end
    end

    assign dot_o        = dot_d;
    assign line_o       = line_d;
    assign dot_adv_o    = adv_s;
    assign visible_o    = (dot_d < H_END) && (line_d < V_END);
    assign dot_zero_o   = (dot_d == 9'd0);
    assign line_zero_o  = (line_d == 9'd0);
    assign frame_tick_o = adv_s && (dot_d == 9'd0) && (line_d == V_END);

endmodule

// File: rtl/nes.sv
// Top of the NES video/controller subsystem: scrolling palette background, h/v markers and
// pad handling. Define NES_SPRITE_EN to add the pad-steered 8x8 player sprite.
module nes
    import nes_pkg::*;
#(
    parameter int H_VIS_P   = H_VIS,
    parameter int H_TOTAL_P = H_TOTAL,
    parameter int V_VIS_P   = V_VIS,
    parameter int V_TOTAL_P = V_TOTAL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  controller,
    output logic [23:0] pixel_color,
    output logic        h,
    output logic        v
);

    logic [CNT_W-1:0] dot_s, line_s;
    logic             dot_adv_s, visible_s, dot_zero_s, line_zero_s, frame_tick_s;

    nes_video_timing #(
        .H_VIS_P   (H_VIS_P),
        .H_TOTAL_P (H_TOTAL_P),
        .V_VIS_P   (V_VIS_P),
        .V_TOTAL_P (V_TOTAL_P)
    ) u_timing (
        .clk_i        (clk),
        .rst_ni       (rst),
        .dot_o        (dot_s),
        .line_o       (line_s),
        .dot_adv_o    (dot_adv_s),
        .visible_o    (visible_s),
        .dot_zero_o   (dot_zero_s),
        .line_zero_o  (line_zero_s),
        .frame_tick_o (frame_tick_s)
    );

    logic [7:0]  pad_q, pad_d;
    logic        paused_q, paused_d;
    logic [5:0]  scroll_q, scroll_d;
    logic        start_rise_s;
    logic        sprite_hit_s;
    logic [5:0]  tile_s;
    logic [23:0] pixel_q, pixel_d;
    logic        h_q, h_d;
    logic        v_q, v_d;
    logic        unused_s;

    // Vblank-start update: sample the pad, toggle pause on a Start press, then advance scroll.
    always_comb begin
        pad_d        = pad_q;
        paused_d     = paused_q;
        scroll_d     = scroll_q;
        start_rise_s = controller[BTN_START] & ~pad_q[BTN_START];
        if (frame_tick_s) begin
            pad_d    = controller;
            paused_d = paused_q ^ start_rise_s;
            if (!paused_d) begin
                scroll_d = scroll_q + 6'd1;
            end else begin
                scroll_d = scroll_q;
            end
        end else begin
            pad_d = pad_q;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_q    <= 8'h00;
            paused_q <= 1'b0;
            scroll_q <= 6'd0;
        end else begin
            pad_q    <= pad_d;
            paused_q <= paused_d;
            scroll_q <= scroll_d;
        end
    end

`ifdef NES_SPRITE_EN
    localparam logic [CNT_W-1:0] SX_HOME = sprite_home(H_VIS_P);
    localparam logic [CNT_W-1:0] SY_HOME = sprite_home(V_VIS_P);
    localparam logic [CNT_W-1:0] SX_MAX  = sprite_max(H_VIS_P);
    localparam logic [CNT_W-1:0] SY_MAX  = sprite_max(V_VIS_P);

    logic [CNT_W-1:0] sx_q, sx_d, sy_q, sy_d;

    // Sprite motion follows the pad once per frame, independent of pause.
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (frame_tick_s) begin
            sx_d = step_clamp(sx_q, controller[BTN_LEFT], controller[BTN_RIGHT], SX_MAX);
            sy_d = step_clamp(sy_q, controller[BTN_UP], controller[BTN_DOWN], SY_MAX);
        end else begin
            sx_d = sx_q;
            sy_d = sy_q;
        end
    end

    // Sprite position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q <= SX_HOME;
            sy_q <= SY_HOME;
        end else begin
            sx_q <= sx_d;
            sy_q <= sy_d;
        end
    end

    assign sprite_hit_s = (dot_s >= sx_q) && (dot_s < (sx_q + 9'd8)) &&
                          (line_s >= sy_q) && (line_s < (sy_q + 9'd8));
    assign unused_s = ^{pad_q[BTN_A], pad_q[BTN_B], pad_q[BTN_SELECT], pad_q[7:4],
                        controller[BTN_A], controller[BTN_B], controller[BTN_SELECT]};
`else
    assign sprite_hit_s = 1'b0;
    assign unused_s = ^{pad_q[BTN_A], pad_q[BTN_B], pad_q[BTN_SELECT], pad_q[7:4],
                        controller[BTN_A], controller[BTN_B], controller[BTN_SELECT],
                        controller[BTN_UP], controller[BTN_DOWN], controller[BTN_LEFT],
                        controller[BTN_RIGHT], dot_s[8], dot_s[2:0], line_s[8], line_s[2:0]};
`endif

    // Pixel and marker values for the dot being entered; held for the rest of the dot.
    always_comb begin
        tile_s  = {1'b0, dot_s[7:3]} + {1'b0, line_s[7:3]} + scroll_q;
        pixel_d = pixel_q;
        h_d     = h_q;
        v_d     = v_q;
        if (dot_adv_s) begin
            if (!visible_s) begin
                pixel_d = 24'h000000;
            end else if (sprite_hit_s) begin
                pixel_d = PALETTE[SPRITE_PAL_IDX];
            end else begin
                pixel_d = PALETTE[tile_s];
            end
            h_d = visible_s & dot_zero_s;
            v_d = dot_zero_s & line_zero_s;
        end else begin
            pixel_d = pixel_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_q <= 24'h000000;
            h_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    assign pixel_color = pixel_q;
    assign h           = h_q;
    assign v           = v_q;

endmodule

// File: tb/tb_nes.sv
// Randomized bench for nes on a reduced raster, checked every clk against a dot-count model.
module tb_nes;

    localparam int HV          = 16;
    localparam int HT          = 17;
    localparam int VV          = 10;
    localparam int VT          = 11;
    localparam int CLK_PER_DOT = 4;
    localparam int FRAME_CLKS  = CLK_PER_DOT * HT * VT;

    localparam logic [23:0] REF_PAL [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  controller;
    logic [23:0] pixel_color;
    logic        h;
    logic        v;

    nes #(
        .H_VIS_P   (HV),
        .H_TOTAL_P (HT),
        .V_VIS_P   (VV),
        .V_TOTAL_P (VT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .controller  (controller),
        .pixel_color (pixel_color),
        .h           (h),
        .v           (v)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: clk edges since reset release, scroll/pause, sprite position.
    int k, scroll, sx, sy, last_h, last_v;
    bit paused, prev_start, h_prev, v_prev;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (clk %0d after release): got %0h, expected %0h", tag, k, got, exp);
        end
    endtask

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic model_reset();
        k          = 0;
        scroll     = 0;
        paused     = 1'b0;
        prev_start = 1'b0;
        sx         = HV / 2 - 4;
        sy         = VV / 2 - 4;
        last_h     = -1;
        last_v     = -1;
        h_prev     = 1'b0;
        v_prev     = 1'b0;
    endtask

    task automatic frame_update(input logic [7:0] pad);
        if (pad[3] && !prev_start) paused = !paused;
        prev_start = pad[3];
        if (!paused) scroll = (scroll + 1) % 64;
`ifdef NES_SPRITE_EN
        sx = clamp(sx + int'(pad[7]) - int'(pad[6]), 0, HV - 8);
        sy = clamp(sy + int'(pad[5]) - int'(pad[4]), 0, VV - 8);
`endif
    endtask

    function automatic logic [23:0] expected_pixel(input int dot, input int line);
        if (dot >= HV || line >= VV) return 24'h000000;
`ifdef NES_SPRITE_EN
        if (dot >= sx && dot < sx + 8 && line >= sy && line < sy + 8) return 24'hFFFEFF;
`endif
        return REF_PAL[(dot / 8 + line / 8 + scroll) % 64];
    endfunction

    // One clk: check the outputs for the current dot, then maybe change the pad at random.
    task automatic step(input logic [7:0] mask, input int odds);
        int g, dot, line;
        @(posedge clk);
        #1;
        g    = k / CLK_PER_DOT;
        dot  = g % HT;
        line = (g / HT) % VT;
        if ((k % CLK_PER_DOT) == 0 && dot == 0 && line == VV) frame_update(controller);
        check_eq("pixel", pixel_color, expected_pixel(dot, line));
        check_eq("h", h, (dot == 0 && line < VV));
        check_eq("v", v, (dot == 0 && line == 0));
        if (h && !h_prev) begin
            if (last_h >= 0 && line != 0) check_eq("h_period", k - last_h, CLK_PER_DOT * HT);
            last_h = k;
        end
        if (v && !v_prev) begin
            if (last_v >= 0) check_eq("v_period", k - last_v, FRAME_CLKS);
            last_v = k;
        end
        h_prev = h;
        v_prev = v;
        k++;
        if (odds > 0 && $urandom_range(odds - 1, 0) == 0) controller = 8'($urandom) & mask;
    endtask

    task automatic run_frames(input int n, input logic [7:0] mask, input int odds);
        repeat (n * FRAME_CLKS) step(mask, odds);
    endtask

    initial begin
        int target;
        rst        = 1'b1;
        controller = 8'h00;
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_eq("rst_pixel", pixel_color, 24'h000000);
        check_eq("rst_h", h, 1'b0);
        check_eq("rst_v", v, 1'b0);
        rst = 1'b1;

        // Free-running scroll past the 63->0 wrap, pad churn without Start.
        run_frames(65, 8'hF7, 300);

        // Start held for three samples toggles once; a second press resumes scrolling.
        controller = 8'h08;
        run_frames(3, 8'h00, 0);
        controller = 8'h00;
        run_frames(2, 8'h00, 0);
        controller = 8'h08;
        run_frames(1, 8'h00, 0);
        controller = 8'h00;
        run_frames(1, 8'h00, 0);

        // Right held long enough to reach the right clamp.
        controller = 8'h80;
        run_frames(6, 8'h00, 0);

        // Fully random pad activity including Start.
        run_frames(4, 8'hFF, 150);

        // Reset in the middle of visible line 5.
        controller = 8'h00;
        target = ((k / FRAME_CLKS) + 1) * FRAME_CLKS + CLK_PER_DOT * (5 * HT + 8) + 2;
        while (k < target) step(8'h00, 0);
        #3;
        rst = 1'b0;
        #1;
        check_eq("midrst_pixel", pixel_color, 24'h000000);
        check_eq("midrst_h", h, 1'b0);
        check_eq("midrst_v", v, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_hold_v", v, 1'b0);
        model_reset();
        rst = 1'b1;
        run_frames(1, 8'h00, 0);
        repeat (200) step(8'h00, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
